// File: rtl/irq_controller_pkg.sv
// Shared constants for the interrupt controller and the CPU-side software model.
//   - Word offsets of the memory-mapped registers (3-bit word address).
//   - Upper bound on the number of interrupt sources and the ID width that
//     covers it (IDs 1..IRQC_MAXSRC, 0 = none).
//   - Fixed source-ID assignments used by the SoC.
package irq_controller_pkg;

   localparam int IRQC_MAXSRC = 31;
   localparam int IRQC_ID_W   = 5;

   typedef enum logic [2:0] {
      IRQC_PENDING   = 3'd0,
      IRQC_ENABLE    = 3'd1,
      IRQC_CLAIM     = 3'd2,
      IRQC_COMPLETE  = 3'd3,
      IRQC_INSERVICE = 3'd4
   } irqc_reg_e;

   localparam logic [IRQC_ID_W-1:0] IRQ_ID_NONE  = 5'd0;
   localparam logic [IRQC_ID_W-1:0] IRQ_ID_TIMER = 5'd1;
   localparam logic [IRQC_ID_W-1:0] IRQ_ID_UART  = 5'd2;
   localparam logic [IRQC_ID_W-1:0] IRQ_ID_SD    = 5'd3;
   localparam logic [IRQC_ID_W-1:0] IRQ_ID_GPIO  = 5'd4;

endpackage

// File: rtl/irq_prio_encoder.sv
// Fixed-priority encoder: returns index+1 of the lowest set bit of vec,
// or 0 when vec is empty. Purely combinational.
//   vec : N-bit request vector (bit 0 has highest priority)
//   id  : winning source ID, 0 = none
module irq_prio_encoder
   import irq_controller_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0]         vec,
   output logic [IRQC_ID_W-1:0] id
);

   // Scan from the top down so the lowest set bit is the last assignment.
   always_comb begin
      id = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) id = IRQC_ID_W'(i + 1);
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller sharing one CPU interrupt line among
// NSRC sources with rising-edge capture, software enable, fixed priority and
// a claim/complete handshake.
//   clk, rst : clock, synchronous active-high reset
//   src      : raw interrupt requests (pulse or level)
//   a        : register word address
//   d, we    : write data and one-cycle write strobe
//   rd       : one-cycle read strobe
//   spo      : registered read data (holds between reads)
//   irq      : registered level interrupt to the CPU
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter int NSRC = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] src,
   input  logic [2:0]      a,
   input  logic [31:0]     d,
   input  logic            we,
   input  logic            rd,
   output logic [31:0]     spo,
   output logic            irq
);

   logic [NSRC-1:0]      src_q_reg;
   logic [NSRC-1:0]      pending_reg, pending_next;
   logic [NSRC-1:0]      enable_reg, enable_next;
   logic [NSRC-1:0]      inservice_reg, inservice_next;
   logic                 irq_reg;
   logic [31:0]          spo_reg, spo_next;

   logic [NSRC-1:0]      src_rise;
   logic [NSRC-1:0]      eligible;
   logic [NSRC-1:0]      claim_clr;
   logic [NSRC-1:0]      complete_clr;
   logic [NSRC-1:0]      w1c_clr;
   logic [IRQC_ID_W-1:0] best_id;
   logic                 do_claim;
   logic                 do_complete;

   assign eligible = pending_reg & enable_reg & ~inservice_reg;

   irq_prio_encoder #(.N(NSRC)) u_prio (
      .vec (eligible),
      .id  (best_id)
   );

   // A simultaneous write suppresses the claim side effect of a read.
   assign do_claim    = rd && !we && (a == IRQC_CLAIM) && (best_id != '0);
   assign do_complete = we && (a == IRQC_COMPLETE);
   assign w1c_clr     = (we && (a == IRQC_PENDING)) ? d[NSRC-1:0] : '0;

   // Comparing d against each ID naturally ignores 0 and out-of-range IDs.
   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : g_src
         assign src_rise[gi]     = src[gi] & ~src_q_reg[gi];
         assign claim_clr[gi]    = do_claim && (best_id == IRQC_ID_W'(gi + 1));
         assign complete_clr[gi] = do_complete && (d == 32'(gi + 1));
      end
   endgenerate

   // New edges are OR-ed in last so a set beats a same-cycle clear.
   assign pending_next   = (pending_reg & ~w1c_clr & ~claim_clr) | src_rise;
   assign inservice_next = (inservice_reg | claim_clr) & ~complete_clr;
   assign enable_next    = (we && (a == IRQC_ENABLE)) ? d[NSRC-1:0] : enable_reg;

   // Read mux uses pre-write register values; CLAIM returns the current winner.
   always_comb begin
      spo_next = spo_reg;
      if (rd) begin
         case (a)
            IRQC_PENDING:   spo_next = 32'(pending_reg);
            IRQC_ENABLE:    spo_next = 32'(enable_reg);
            IRQC_CLAIM:     spo_next = 32'(best_id);
            IRQC_INSERVICE: spo_next = 32'(inservice_reg);
            default:        spo_next = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_q_reg     <= '0;
         pending_reg   <= '0;
         enable_reg    <= '0;
         inservice_reg <= '0;
         irq_reg       <= 1'b0;
         spo_reg       <= '0;
      end else begin
         src_q_reg     <= src;
         pending_reg   <= pending_next;
         enable_reg    <= enable_next;
         inservice_reg <= inservice_next;
         irq_reg       <= |eligible;
         spo_reg       <= spo_next;
      end
   end

   assign spo = spo_reg;
   assign irq = irq_reg;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

   localparam int NSRC = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [NSRC-1:0] src;
   logic [2:0]      a;
   logic [31:0]     d;
   logic            we;
   logic            rd;
   logic [31:0]     spo;
   logic            irq;

   int errors = 0;
   int checks = 0;

   irq_controller #(.NSRC(NSRC)) dut (
      .clk (clk),
      .rst (rst),
      .src (src),
      .a   (a),
      .d   (d),
      .we  (we),
      .rd  (rd),
      .spo (spo),
      .irq (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic        rd;
      logic [2:0]  a;
      logic [31:0] d;
      logic [7:0]  src;
      logic        chk_spo;
      logic [31:0] exp_spo;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic w, input logic r, input logic [2:0] ad,
                      input logic [31:0] dd, input logic [7:0] s,
                      input logic cs, input logic [31:0] es, input logic ei);
      vec_t v;
      v.we = w; v.rd = r; v.a = ad; v.d = dd; v.src = s;
      v.chk_spo = cs; v.exp_spo = es; v.exp_irq = ei;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   // Advance one clock; inputs and samples sit 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; rd = 1'b0; a = '0; d = '0;
   endtask

   task automatic rd_reg(input logic [2:0] ad, input logic [31:0] exp, input string name);
      rd = 1'b1; a = ad;
      tick();
      idle();
      chk(name, spo, exp);
   endtask

   task automatic do_reset(input logic [NSRC-1:0] s);
      rst = 1'b1; src = s; idle();
      tick(); tick();
      rst = 1'b0;
   endtask

   int w;
   int n;
   int spurious;
   int claims;

   initial begin
      // {we, rd, a, d, src, chk_spo, exp_spo, exp_irq}; state after each edge.
      add(1,0,1,32'h01,8'h00,0,32'h00,0);
      add(0,0,0,32'h00,8'h01,0,32'h00,0);
      add(0,1,0,32'h00,8'h00,1,32'h01,1);
      add(0,1,2,32'h00,8'h00,1,32'h01,1);
      add(0,1,0,32'h00,8'h00,1,32'h00,0);
      add(0,1,4,32'h00,8'h00,1,32'h01,0);
      add(1,0,1,32'hFF,8'h00,0,32'h00,0);
      add(0,0,0,32'h00,8'h24,0,32'h00,0);
      add(0,1,0,32'h00,8'h00,1,32'h24,1);
      add(0,1,2,32'h00,8'h00,1,32'h03,1);
      add(0,1,2,32'h00,8'h00,1,32'h06,1);
      add(0,1,2,32'h00,8'h00,1,32'h00,0);
      add(0,1,0,32'h00,8'h00,1,32'h00,0);
      add(0,1,4,32'h00,8'h00,1,32'h25,0);
      add(1,0,3,32'h03,8'h00,0,32'h00,0);
      add(1,0,3,32'h06,8'h00,0,32'h00,0);
      add(0,1,4,32'h00,8'h00,1,32'h01,0);
      add(0,0,0,32'h00,8'h01,0,32'h00,0);
      add(0,1,0,32'h00,8'h00,1,32'h01,0);
      add(1,0,3,32'h01,8'h00,0,32'h00,0);
      add(0,1,4,32'h00,8'h00,1,32'h00,1);
      add(0,1,2,32'h00,8'h00,1,32'h01,1);
      add(0,1,4,32'h00,8'h00,1,32'h01,0);
      add(0,0,0,32'h00,8'h02,0,32'h00,0);
      add(0,1,0,32'h00,8'h00,1,32'h02,1);
      add(0,1,2,32'h00,8'h02,1,32'h02,1);
      add(0,1,0,32'h00,8'h00,1,32'h02,0);
      add(1,0,3,32'h00,8'h00,0,32'h00,0);
      add(1,0,3,32'h09,8'h00,0,32'h00,0);
      add(1,0,3,32'h05,8'h00,0,32'h00,0);
      add(0,1,4,32'h00,8'h00,1,32'h03,0);
      add(1,0,0,32'h02,8'h02,0,32'h00,0);
      add(0,1,0,32'h00,8'h00,1,32'h02,0);
      add(0,1,4,32'h00,8'h00,1,32'h03,0);
      add(1,1,1,32'h0F,8'h00,1,32'hFF,0);
      add(0,1,1,32'h00,8'h00,1,32'h0F,0);
      add(1,0,3,32'h02,8'h00,0,32'h00,0);
      add(1,1,2,32'h00,8'h00,1,32'h02,1);
      add(0,1,0,32'h00,8'h00,1,32'h02,1);
      add(1,0,1,32'h00,8'h00,0,32'h00,1);
      add(0,1,0,32'h00,8'h00,1,32'h02,0);
      add(0,1,5,32'h00,8'h00,1,32'h00,0);
      add(1,0,1,32'hFFFFFF03,8'h00,0,32'h00,0);
      add(0,1,1,32'h00,8'h00,1,32'h03,1);
      add(1,0,3,32'h01,8'h01,0,32'h00,1);
      add(0,1,4,32'h00,8'h00,1,32'h00,1);
      add(0,1,0,32'h00,8'h00,1,32'h03,1);

      // Reset state
      do_reset('0);
      chk("reset irq", {31'd0, irq}, 32'd0);
      chk("reset spo", spo, 32'd0);
      rd_reg(3'd0, 32'd0, "reset PENDING");
      rd_reg(3'd1, 32'd0, "reset ENABLE");
      rd_reg(3'd4, 32'd0, "reset INSERVICE");

      // Directed vector table
      for (int i = 0; i < vecs.size(); i++) begin
         we = vecs[i].we; rd = vecs[i].rd; a = vecs[i].a;
         d = vecs[i].d; src = vecs[i].src;
         tick();
         chk($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
         if (vecs[i].chk_spo)
            chk($sformatf("vec%0d spo", i), spo, vecs[i].exp_spo);
      end
      idle(); src = '0;

      // Source held high across reset release: exactly one edge captured.
      do_reset(8'h01);
      tick();
      rd_reg(3'd0, 32'h01, "held-high edge PENDING");
      we = 1'b1; a = 3'd0; d = 32'h01;
      tick();
      idle();
      rd_reg(3'd0, 32'h00, "held-high no re-set");
      src = '0;

      // Periodic timer with CPU claim/complete
      do_reset('0);
      we = 1'b1; a = 3'd1; d = 32'h01;
      tick();
      idle();
      spurious = 0;
      claims   = 0;
      for (int p = 0; p < 20; p++) begin
         src = 8'h01;
         tick();
         src = '0;
         n = 1;
         w = 0;
         while (!irq && w < 8) begin
            tick(); w++; n++;
         end
         chk($sformatf("period%0d irq seen", p), {31'd0, irq}, 32'd1);
         repeat (10) tick();
         n += 10;
         rd = 1'b1; a = 3'd2;
         tick();
         idle();
         n++;
         chk($sformatf("period%0d claim id", p), spo, 32'd1);
         if (spo == 32'd1) claims++;
         we = 1'b1; a = 3'd3; d = 32'd1;
         tick();
         idle();
         n++;
         while (n < 4001) begin
            if (irq) spurious++;
            tick(); n++;
         end
      end
      chk("periodic claim count", 32'(claims), 32'd20);
      chk("periodic spurious irq", 32'(spurious), 32'd0);

      // Reset in the middle of service
      src = 8'h01;
      tick();
      src = '0;
      tick();
      chk("mid irq before claim", {31'd0, irq}, 32'd1);
      rd_reg(3'd2, 32'd1, "mid claim id");
      rd_reg(3'd4, 32'd1, "mid INSERVICE before rst");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid rst irq", {31'd0, irq}, 32'd0);
      chk("mid rst spo", spo, 32'd0);
      rd_reg(3'd0, 32'd0, "mid rst PENDING");
      rd_reg(3'd1, 32'd0, "mid rst ENABLE");
      rd_reg(3'd4, 32'd0, "mid rst INSERVICE");
      tick();
      chk("mid rst irq later", {31'd0, irq}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller that shares the single CPU interrupt line among up to NSRC requesters: timer, UART, SD, GPIO.
- Latches rising edges per source into a pending register and masks them with a software enable.
- Arbitrates by fixed priority and tracks in-service sources with a claim/complete register handshake.
- Sits between the peripheral irq outputs and the CPU external-interrupt input, on the CPU's I/O bus.

Parameters:
- NSRC, 8, number of interrupt sources (1..31); source i has ID i+1, ID 0 means "none".

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- src  input  NSRC  raw interrupt requests; pulse or level, synchronous to clk
- a  input  3  word address of register
- d  input  32  write data
- we  input  1  write strobe, one cycle per write
- rd  input  1  read strobe, one cycle per read
- spo  output  32  read data, registered
- irq  output  1  level interrupt request to CPU

Behaviour:
- Registers by word address a:
  - 0 PENDING: read-only view; write-1-to-clear.
  - 1 ENABLE: RW, bits [NSRC-1:0].
  - 2 CLAIM: read-only.
  - 3 COMPLETE: write-only.
  - 4 INSERVICE: read-only.
  - 5-7: read 0, writes ignored.
  - Unimplemented upper bits read 0.
- Reset: pending=0, enable=0, inservice=0, src_q=0, irq=0, spo=0.
- Edge capture:
  - src_q <= src every cycle.
  - pending[i] is set in the cycle where src[i]=1 and src_q[i]=0.
  - A source held high across reset release therefore registers one edge in the first post-reset cycle.
  - A level held high produces exactly one pending set until it drops.
- Eligibility: eligible = pending & enable & ~inservice.
- irq <= |eligible, registered, so irq follows eligibility with 1-cycle latency.
- Priority: lowest index wins; best_id = index+1 of the lowest set bit of eligible, or 0.
- Reads: spo <= selected register one cycle after the rd cycle; spo holds its value otherwise.
- CLAIM read (rd=1, a=2):
  - spo <= best_id, computed in the rd cycle.
  - If best_id != 0, at the same clock edge pending[best_id-1] is cleared and inservice[best_id-1] is set.
  - Claim with nothing eligible returns 0 and has no side effects.
- COMPLETE write (we=1, a=3): if 1 <= d <= NSRC, clear inservice[d-1]. Other values are ignored, as is completing a non-in-service ID.
- Pending of an in-service source:
  - New edges set pending but are not eligible until complete.
  - After complete, irq reasserts next cycle if the source is still pending and enabled.
- Simultaneous events:
  - Edge on src[i] in the same cycle as a claim or W1C clear of bit i: the set wins and pending stays 1.
  - Edge arriving in the same cycle as a complete of the same ID: pending=1 and inservice=0 afterwards.
- Disabling an enabled pending source drops irq next cycle. Pending is retained.
- we and rd in the same cycle:
  - The write is performed.
  - Read side effects (the claim) are suppressed.
  - spo returns the pre-write register value.
- Reset mid-operation clears all state including inservice; any outstanding claim is abandoned.
- Width: NSRC-bit internal vectors are zero-extended to 32 on read. Out-of-range written bits [31:NSRC] are ignored.

Decomposition:
- pCPU.vh holds:
  - register offsets IRQC_PENDING/ENABLE/CLAIM/COMPLETE/INSERVICE;
  - IRQC_MAXSRC=31;
  - source-ID assignments (timer=1, uart=2, sd=3, gpio=4).
- One combinational sub-module, irq_prio_encoder (NSRC-bit vector to ID, 0 if empty), shared with a future vectored-interrupt path.
- Edge capture, register file and claim/complete logic stay in irq_controller.

Test Plan:
- Reset, ENABLE=0x01, 1-cycle pulse on src[0] -> PENDING=0x01 next cycle, irq=1 one cycle later; CLAIM read returns 1, PENDING=0, INSERVICE=0x01, irq=0.
- ENABLE=0xFF, pulse src[5] and src[2] in the same cycle -> first CLAIM returns 3, second returns 6; third returns 0 with no state change; COMPLETE d=3 then d=6 -> INSERVICE=0.
- src[0] in service, new pulse on src[0] -> PENDING=0x01, irq stays 0; COMPLETE d=1 -> irq=1 the following cycle.
- Edge on src[1] in the same cycle as the CLAIM read that claims ID 2 -> CLAIM returns 2, PENDING bit1 remains 1.
- Writes COMPLETE d=0, d=9, and an ID not in service; W1C PENDING with 0x02 while src[1] edges the same cycle -> no INSERVICE change; PENDING bit1 stays set.
- Periodic timer pulse every 4001 cycles with ENABLE=0x01, CPU claim/complete 10 cycles after each irq -> exactly one claim per period, no lost or duplicate IDs over 20 periods; assert rst mid-service -> all registers 0, irq=0.
